alu_md: RTL and testbench
=========================

# alu_md

Execute-stage multiply/divide unit with architectural HI/LO registers. It consumes the 3-bit multiply/divide operation code produced by the E-stage controller, together with forwarded RS/RT values. It runs mult/multu/div/divu over a fixed multi-cycle latency and raises `busy` so the hazard unit can stall dependent instructions. It also returns HI or LO for mfhi/mflo on the E-stage result path.

## Interface
- `MUL_CYCLES`, default 5: busy cycles for mult/multu (range 1..15).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (range 1..15).
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `A` in 32: RS operand (dividend / multiplicand), forwarded value.
- `B` in 32: RT operand (divisor / multiplier), forwarded value.
- `ALU_MD_ctrl` in 3: 000 mult, 001 multu, 010 div, 011 divu, 100 mfhi, 101 mflo (110/111 see Configuration).
- `start` in 1: high for exactly the one E-stage cycle of a mult/multu/div/divu (or mthi/mtlo) instruction.
- `busy` out 1: operation in flight.
- `HI` out 32: HI register.
- `LO` out 32: LO register.
- `out` out 32: `HI` when `ALU_MD_ctrl`=100, otherwise `LO`. Combinational from the registers.

## Operation
- Reset: `busy`=0, `HI`=0, `LO`=0, counter=0, pending result=0, state IDLE.
- States:
  - IDLE: `start` with code 000–011 computes the result from `A`/`B` at that edge, latches it into pending HI/LO, loads the counter with MUL_CYCLES or DIV_CYCLES, and moves to BUSY.
  - BUSY: the counter decrements each cycle. When the counter is 1, the next edge commits pending→HI/LO, clears `busy`, and returns to IDLE.
- Arithmetic:
  - mult: signed 32×32→64, HI=[63:32], LO=[31:0].
  - multu: unsigned 32×32→64, same split.
  - div: signed, quotient truncates toward zero; LO=quotient, HI=remainder with the sign of the dividend.
  - divu: unsigned, LO=quotient, HI=remainder.
- Boundaries:
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - B=0 for div or divu: full DIV_CYCLES busy, HI/LO unchanged at commit.
  - `start` while BUSY: ignored. The hazard unit guarantees this never occurs; the unit must not corrupt the in-flight result.
  - `start` with code 100/101: ignored.
  - `reset` in any cycle: aborts the op, discards pending, all outputs return to reset values on the next edge. No late commit.
- mfhi/mflo during BUSY return the old HI/LO. The stall logic prevents this from occurring.

## Timing
- `start` high in cycle T: `busy`=1 in cycles T+1 … T+N, where N is MUL_CYCLES or DIV_CYCLES.
- New HI/LO are visible from cycle T+N+1, the same cycle `busy` falls.
- Back-to-back: a new `start` is accepted in cycle T+N+1. There are no idle gap cycles.
- `out` has zero-cycle latency from `ALU_MD_ctrl`, `HI` and `LO`.
- Stall contract: D stage stalls any md instruction while `start`||`busy`.

## Configuration
- `ALU_MD_MTHI_EN` defined:
  - `start` with code 110 (mthi) writes `A` into HI at that edge.
  - Code 111 (mtlo) writes `A` into LO at that edge.
  - Neither asserts `busy`.
  - Both are ignored while BUSY.
- Not defined: codes 110/111 are treated as ignored, and `out` selects LO for them.

## Structure
- Package `md_pkg`:
  - Opcode constants MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO.
  - Default latencies MUL_CYCLES_DEF=5, DIV_CYCLES_DEF=10.
  - State encoding IDLE/BUSY.
- Sub-module `md_calc`: purely combinational. Takes A, B and the code; returns the 64-bit {hi,lo} result, including the signed/unsigned and div-by-zero/overflow rules. `alu_md` holds the FSM, counter, pending and HI/LO registers.

## Test plan
- mult A=0xFFFFFFFF, B=0x00000002: `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands: HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=0xFFFFFFF9, B=2: `busy` high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Follow with divu A=7, B=2: LO=3, HI=1.
- div B=0 with HI=0x11, LO=0x22 preloaded: `busy` high 10 cycles, HI/LO still 0x11/0x22. Then div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- mult in flight:
  - Assert `reset` in busy cycle 3: `busy`=0, HI=LO=0 next cycle, no change after.
  - Separately, `start` with div in busy cycle 2: ignored, mult result commits on schedule.
- With `ALU_MD_MTHI_EN`:
  - `start` with code 110, A=0x1234: HI=0x1234 next cycle, `busy` stays 0.
  - Then code 100 gives `out`=0x1234 and code 101 gives `out`=LO.
  - Without the macro, the same stimulus leaves HI unchanged.

Source files
------------

// File: rtl/md_pkg.sv
// Shared opcodes, default latencies and FSM encoding
// for the execute-stage multiply/divide unit.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MFHI  = 3'b100;
  localparam logic [2:0] MD_MFLO  = 3'b101;
  localparam logic [2:0] MD_MTHI  = 3'b110;
  localparam logic [2:0] MD_MTLO  = 3'b111;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Codes 000..011 start a timed arithmetic op.
  function automatic logic is_arith(
    input logic [2:0] op
  );
    return op[2] == 1'b0;
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational mult/multu/div/divu datapath.
// Ports: a, b, op in; res = {hi,lo}, wr = 0 when HI/LO must stay.
module md_calc
  import md_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [63:0] res,
  output logic        wr
);

  logic [63:0] sa;
  logic [63:0] sb;
  logic [63:0] ua;
  logic [63:0] ub;
  logic [63:0] sprod;
  logic [63:0] uprod;
  logic        b_zero;
  logic        ovf;

  assign sa = {{32{a[31]}}, a};
  assign sb = {{32{b[31]}}, b};
  assign ua = {32'h0, a};
  assign ub = {32'h0, b};

  // Low 64 bits of the sign-extended product equal
  // the exact signed 32x32 product.
  assign sprod = sa * sb;
  assign uprod = ua * ub;

  assign b_zero = (b == 32'h0);

  // INT_MIN / -1 does not fit; pin it explicitly.
  assign ovf = (a == 32'h8000_0000) &&
               (b == 32'hffff_ffff);

  always_comb begin
    res = 64'h0;
    wr  = 1'b0;
    case (op)
      MD_MULT: begin
        res = sprod;
        wr  = 1'b1;
      end
      MD_MULTU: begin
        res = uprod;
        wr  = 1'b1;
      end
      MD_DIV: begin
        if (b_zero) begin
          wr = 1'b0;
        end else if (ovf) begin
          res = {32'h0, 32'h8000_0000};
          wr  = 1'b1;
        end else begin
          res[31:0]  = $signed(a) / $signed(b);
          res[63:32] = $signed(a) % $signed(b);
          wr         = 1'b1;
        end
      end
      MD_DIVU: begin
        if (!b_zero) begin
          res[31:0]  = a / b;
          res[63:32] = a % b;
          wr         = 1'b1;
        end
      end
      default: begin
        res = 64'h0;
        wr  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_md.sv
// E-stage multiply/divide unit with HI/LO and fixed latency busy.
// Ports: clk, reset (sync, high), A, B, ALU_MD_ctrl, start ->
//   busy, HI, LO, out. Option macro: ALU_MD_MTHI_EN (mthi/mtlo).
module alu_md
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALU_MD_ctrl,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  md_state_e   state_q;
  md_state_e   state_d;
  logic [3:0]  cnt_q;
  logic [63:0] pend_q;
  logic        pend_wr_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [63:0] calc_res;
  logic        calc_wr;
  logic        go;
  logic        last;

  md_calc u_calc (
    .a   (A),
    .b   (B),
    .op  (ALU_MD_ctrl),
    .res (calc_res),
    .wr  (calc_wr)
  );

  assign go   = start && is_arith(ALU_MD_ctrl);
  assign last = (cnt_q == 4'd1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = BUSY;
      BUSY: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pend_q    <= 64'h0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (go) begin
            pend_q    <= calc_res;
            pend_wr_q <= calc_wr;
            cnt_q     <= ALU_MD_ctrl[1] ? DIV_N : MUL_N;
          end
`ifdef ALU_MD_MTHI_EN
          else if (start &&
                   ALU_MD_ctrl == MD_MTHI) begin
            hi_q <= A;
          end else if (start &&
                       ALU_MD_ctrl == MD_MTLO) begin
            lo_q <= A;
          end
`endif
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          // Divide-by-zero leaves HI/LO untouched.
          if (last && pend_wr_q) begin
            hi_q <= pend_q[63:32];
            lo_q <= pend_q[31:0];
          end
        end
        default: cnt_q <= 4'd0;
      endcase
    end
  end

  assign busy = (state_q == BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign out  = (ALU_MD_ctrl == MD_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Randomized + directed bench for alu_md against a
// behavioural HI/LO model.
module tb_alu_md;

  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ctrl;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;
  logic [31:0] p_hi = 0;
  logic [31:0] p_lo = 0;
  bit          p_keep = 0;
  int          rem = 0;

  alu_md dut (
    .clk         (clk),
    .reset       (reset),
    .A           (A),
    .B           (B),
    .ALU_MD_ctrl (ctrl),
    .start       (start),
    .busy        (busy),
    .HI          (HI),
    .LO          (LO),
    .out         (out)
  );

  always #5 clk = ~clk;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference result as {hi,lo} from plain integer math.
  function automatic logic [63:0] ref_calc(
    input logic [2:0] c,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa, sb, ua, ub, p, q, r, ma, mb;
    logic [63:0] v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    v = 0;
    case (c)
      3'd0: begin p = sa * sb; v = p; end
      3'd1: begin p = ua * ub; v = p; end
      3'd2: begin
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        q = ma / mb;
        if ((sa < 0) != (sb < 0)) q = -q;
        r = sa - q * sb;
        v = {r[31:0], q[31:0]};
      end
      default: begin
        q = ua / ub;
        r = ua % ub;
        v = {r[31:0], q[31:0]};
      end
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    logic [63:0] r;
    if (reset) begin
      m_hi = 0; m_lo = 0;
      p_hi = 0; p_lo = 0;
      p_keep = 0; rem = 0;
    end else if (rem > 0) begin
      if (rem == 1 && !p_keep) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      rem--;
    end else if (start) begin
      if (ctrl <= 3'd3) begin
        p_keep = (ctrl >= 3'd2) && (B == 0);
        if (!p_keep) begin
          r = ref_calc(ctrl, A, B);
          p_hi = r[63:32];
          p_lo = r[31:0];
        end
        rem = (ctrl >= 3'd2) ? DIVN : MULN;
      end
`ifdef ALU_MD_MTHI_EN
      else if (ctrl == 3'd6) m_hi = A;
      else if (ctrl == 3'd7) m_lo = A;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(rem > 0));
      chk("hi", HI, m_hi);
      chk("lo", LO, m_lo);
      chk("out", out,
          (ctrl == 3'd4) ? m_hi : m_lo);
    end
  end

  task automatic run_op(string name,
                        logic [2:0] c,
                        logic [31:0] a,
                        logic [31:0] b,
                        int exp_n);
    int n;
    @(posedge clk); #1;
    ctrl = c; A = a; B = b; start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk({name, "_len"}, n, exp_n);
  endtask

  task automatic pin(string name,
                     logic [31:0] h,
                     logic [31:0] l);
    chk({name, "_HI"}, HI, h);
    chk({name, "_LO"}, LO, l);
    chk({name, "_mHI"}, m_hi, h);
    chk({name, "_mLO"}, m_lo, l);
  endtask

  initial begin
    int n;
    reset = 1; start = 0;
    ctrl = 3'd5; A = 0; B = 0;
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    pin("rst", 0, 0);

    run_op("mult", 3'd0, 32'hffff_ffff, 2, 5);
    pin("mult", 32'hffff_ffff, 32'hffff_fffe);
    run_op("multu", 3'd1, 32'hffff_ffff, 2, 5);
    pin("multu", 32'h1, 32'hffff_fffe);
    run_op("div", 3'd2, 32'hffff_fff9, 2, 10);
    pin("div", 32'hffff_ffff, 32'hffff_fffd);
    run_op("divu", 3'd3, 7, 2, 10);
    pin("divu", 1, 3);
    run_op("pre", 3'd1, 32'h22, 32'h8000_0001, 5);
    pin("pre", 32'h11, 32'h22);
    run_op("div0", 3'd2, 32'h1234, 0, 10);
    pin("div0", 32'h11, 32'h22);
    run_op("ovf", 3'd2, 32'h8000_0000,
           32'hffff_ffff, 10);
    pin("ovf", 0, 32'h8000_0000);

    // Reset in busy cycle 3 of a mult.
    @(posedge clk); #1;
    ctrl = 3'd0; A = 9; B = 9; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    pin("abort", 0, 0);
    repeat (8) @(negedge clk);
    pin("abort_late", 0, 0);

    // div start during busy cycle 2 is dropped.
    @(posedge clk); #1;
    ctrl = 3'd0; A = 3; B = 5; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    ctrl = 3'd2; A = 100; B = 7; start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("ign_len", n, 3);
    pin("ign", 0, 15);

    // mthi: either writes HI or is ignored.
    @(posedge clk); #1;
    ctrl = 3'd6; A = 32'h1234; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("mthi_busy", 32'(busy), 0);
`ifdef ALU_MD_MTHI_EN
    pin("mthi", 32'h1234, 15);
    ctrl = 3'd4; #1;
    chk("mfhi_out", out, 32'h1234);
`else
    pin("mthi", 0, 15);
    ctrl = 3'd4; #1;
    chk("mfhi_out", out, 0);
`endif
    ctrl = 3'd5; #1;
    chk("mflo_out", out, 15);

    // Random traffic, including stray starts and resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 249) == 0);
      start = ($urandom_range(0, 2) == 0);
      ctrl = 3'($urandom_range(0, 7));
      A = $urandom;
      B = $urandom;
      case ($urandom_range(0, 7))
        0: B = 0;
        1: B = 32'hffff_ffff;
        2: B = $urandom_range(1, 9);
        3: A = 32'h8000_0000;
        default: ;
      endcase
    end
    @(posedge clk); #1;
    reset = 0; start = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
